// File: rtl/data_mem.sv
// Word-organised 32-bit data memory: byte/half/word loads and stores after WAIT_STATES
// wait cycles, with little-endian lane steering, load extension and alignment rejection.
module data_mem #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] r_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [31:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  uns_q, uns_d;
  logic                  wr_q, wr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        req_err;
  logic        access;
  logic [31:0] word_rd;
  logic [7:0]  byte_rd;
  logic [15:0] half_rd;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wlane;

  assign req_err = (MemRead == MemWrite) || (size == 2'b11) ||
                   ((size == 2'b01) && addr[0]) ||
                   ((size == 2'b10) && (addr[1:0] != 2'b00));
  assign access  = (state_q == S_BUSY) && (cnt_q == 4'd0);

  // Load path: pick lane(s) from the latched offset, right-justify, extend
  always_comb begin
    word_rd = mem[idx_q];
    byte_rd = 8'(word_rd >> {off_q, 3'b000});
    half_rd = off_q[1] ? word_rd[31:16] : word_rd[15:0];
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & byte_rd[7]}}, byte_rd};
      2'b01:   load_val = {{16{~uns_q & half_rd[15]}}, half_rd};
      default: load_val = word_rd;
    endcase
  end

  // Store path: replicate right-justified data across lanes, enable only the target lanes
  always_comb begin
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << off_q;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = off_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_err) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            idx_d   = addr[ADDR_WIDTH+1:2];
            off_d   = addr[1:0];
            size_d  = size;
            wdata_d = wr_data;
            uns_d   = unsigned_ld;
            wr_d    = MemWrite;
            cnt_d   = WAIT_INIT;
            state_d = S_BUSY;
          end
        end
      end
      default: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!wr_q) rdata_d = load_val;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; a reset on the completing edge suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign r_data = rdata_q;
  assign busy   = (state_q == S_BUSY);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: table of single requests plus hand-written sequences
// for busy-time input changes, back-to-back issue and reset during an access.
module tb_data_mem;

  localparam int unsigned WS = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] r_data;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  data_mem #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req(req), .MemRead(MemRead), .MemWrite(MemWrite),
    .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wr_data(wr_data),
    .r_data(r_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic        xerr;
    logic [31:0] xrd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; MemRead = rd; MemWrite = wr; size = sz;
    unsigned_ld = uns; addr = a; wr_data = wd;
  endtask

  // Bounded wait for done; returns number of rising edges waited (0 if already high)
  task automatic wait_done(output int unsigned n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_req(input vec_t v);
    int unsigned n;
    @(negedge clk);
    drive(v.rd, v.wr, v.sz, v.uns, v.a, v.wd);
    @(posedge clk); #1;
    req = 1'b0;
    chk({v.nm, ".busy"}, 32'(busy), 32'(!v.xerr));
    wait_done(n);
    chk({v.nm, ".lat"}, n, v.xerr ? 32'd0 : 32'(WS + 1));
    chk({v.nm, ".err"}, 32'(err), 32'(v.xerr));
    chk({v.nm, ".rdata"}, r_data, v.xrd);
    chk({v.nm, ".busy_end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({v.nm, ".pulse"}, {30'd0, done, err}, 32'd0);
  endtask

  initial begin
    int unsigned n;
    logic        saw_done;

    vecs.push_back('{"sw10",   1'b0, 1'b1, 2'b10, 1'b0, 32'h10,   32'h8765_4321, 1'b0, 32'h0000_0000});
    vecs.push_back('{"lw10",   1'b1, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         1'b0, 32'h8765_4321});
    vecs.push_back('{"sb11",   1'b0, 1'b1, 2'b00, 1'b0, 32'h11,   32'h0000_00AA, 1'b0, 32'h8765_4321});
    vecs.push_back('{"lb11",   1'b1, 1'b0, 2'b00, 1'b0, 32'h11,   32'h0,         1'b0, 32'hFFFF_FFAA});
    vecs.push_back('{"lbu11",  1'b1, 1'b0, 2'b00, 1'b1, 32'h11,   32'h0,         1'b0, 32'h0000_00AA});
    vecs.push_back('{"lw10b",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         1'b0, 32'h8765_AA21});
    vecs.push_back('{"sh12",   1'b0, 1'b1, 2'b01, 1'b0, 32'h12,   32'h0000_1234, 1'b0, 32'h8765_AA21});
    vecs.push_back('{"lh12",   1'b1, 1'b0, 2'b01, 1'b0, 32'h12,   32'h0,         1'b0, 32'h0000_1234});
    vecs.push_back('{"lb13",   1'b1, 1'b0, 2'b00, 1'b0, 32'h13,   32'h0,         1'b0, 32'h0000_0012});
    vecs.push_back('{"lw10c",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         1'b0, 32'h1234_AA21});
    vecs.push_back('{"e_lw02", 1'b1, 1'b0, 2'b10, 1'b0, 32'h02,   32'h0,         1'b1, 32'h1234_AA21});
    vecs.push_back('{"e_lh01", 1'b1, 1'b0, 2'b01, 1'b0, 32'h01,   32'h0,         1'b1, 32'h1234_AA21});
    vecs.push_back('{"e_sz11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10,   32'h0,         1'b1, 32'h1234_AA21});
    vecs.push_back('{"e_rw11", 1'b1, 1'b1, 2'b10, 1'b0, 32'h10,   32'h0,         1'b1, 32'h1234_AA21});
    vecs.push_back('{"e_rw00", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         1'b1, 32'h1234_AA21});
    vecs.push_back('{"e_sw12", 1'b0, 1'b1, 2'b10, 1'b0, 32'h12,   32'hFFFF_FFFF, 1'b1, 32'h1234_AA21});
    vecs.push_back('{"e_sh13", 1'b0, 1'b1, 2'b01, 1'b0, 32'h13,   32'h0000_FFFF, 1'b1, 32'h1234_AA21});
    vecs.push_back('{"lw10d",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         1'b0, 32'h1234_AA21});
    vecs.push_back('{"sh14",   1'b0, 1'b1, 2'b01, 1'b0, 32'h14,   32'h0000_8001, 1'b0, 32'h1234_AA21});
    vecs.push_back('{"lh14",   1'b1, 1'b0, 2'b01, 1'b0, 32'h14,   32'h0,         1'b0, 32'hFFFF_8001});
    vecs.push_back('{"lhu14",  1'b1, 1'b0, 2'b01, 1'b1, 32'h14,   32'h0,         1'b0, 32'h0000_8001});
    vecs.push_back('{"sw18",   1'b0, 1'b1, 2'b10, 1'b0, 32'h18,   32'h1122_3344, 1'b0, 32'h0000_8001});
    vecs.push_back('{"sb1a",   1'b0, 1'b1, 2'b00, 1'b0, 32'h1A,   32'hDEAD_BE55, 1'b0, 32'h0000_8001});
    vecs.push_back('{"lw18",   1'b1, 1'b0, 2'b10, 1'b0, 32'h18,   32'h0,         1'b0, 32'h1155_3344});
    vecs.push_back('{"sw1000", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h0BAD_F00D, 1'b0, 32'h1155_3344});
    vecs.push_back('{"lw0",    1'b1, 1'b0, 2'b10, 1'b0, 32'h0,    32'h0,         1'b0, 32'h0BAD_F00D});
    vecs.push_back('{"lb1a",   1'b1, 1'b0, 2'b00, 1'b0, 32'h1A,   32'h0,         1'b0, 32'h0000_0055});
    vecs.push_back('{"sw24",   1'b0, 1'b1, 2'b10, 1'b0, 32'h24,   32'h5555_AAAA, 1'b0, 32'h0000_0055});

    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdata", r_data, 32'h0);
    chk("rst.flags", {29'd0, busy, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) do_req(vecs[i]);

    // Input changes and req during BUSY must not disturb the latched store
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_BABE);
    @(posedge clk); #1;
    chk("bsy.busy0", 32'(busy), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h24, 32'h0);
    @(posedge clk); #1;
    chk("bsy.mid", {30'd0, busy, done}, 32'b10);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("bsy.done", {29'd0, busy, done, err}, 32'b010);
    @(posedge clk); #1;
    chk("bsy.after", {29'd0, busy, done, err}, 32'b000);
    chk("bsy.rdata", r_data, 32'h0000_0055);
    do_req('{"lw20", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE_BABE});
    do_req('{"lw24", 1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 1'b0, 32'h5555_AAAA});

    // Back-to-back: second request raised in the done cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    wait_done(n);
    chk("b2b.lat1", n, 32'(WS + 1));
    chk("b2b.rd1", r_data, 32'h1234_AA21);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    chk("b2b.busy2", 32'(busy), 32'd1);
    wait_done(n);
    chk("b2b.period", n + 1, 32'(WS + 2));
    chk("b2b.rd2", r_data, 32'h1155_3344);
    @(posedge clk); #1;

    // Reset during BUSY aborts the store and suppresses done
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstb.busy", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("rstb.nodone", 32'(saw_done), 32'd0);
    chk("rstb.rdata", r_data, 32'h0);
    do_req('{"lw20r", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE_BABE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
